// File: rtl/mem_stage.sv
// Memory stage: request/acknowledge handshake with a variable-latency data memory, upstream stall, MEM/WB register.
// Optional build macro ALIGN_CHECK_EN: misaligned (odd-address) accesses fail immediately without touching memory.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ALURes,
    input  logic [15:0] readData2,
    input  logic [15:0] nextPC,
    input  logic [2:0]  writeReg,
    input  logic        regWrite,
    input  logic        memToReg,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        halt,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] readDataOut,
    output logic [15:0] ALUResOut,
    output logic [15:0] nextPCOut,
    output logic [2:0]  writeRegOut,
    output logic        regWriteOut,
    output logic        memToRegOut,
    output logic        haltOut,
    output logic        errOut
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        access;
    logic        misalign;

    assign access = memRead | memWrite;

`ifdef ALIGN_CHECK_EN
    assign misalign = ALURes[0];
`else
    assign misalign = 1'b0;
`endif

    assign stall = ((state_q == IDLE) && access) || (state_q == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            rdata_q   <= 16'd0;
            err_q     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (misalign) begin
                            rdata_q <= 16'd0;
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= memWrite;
                            mem_addr  <= ALURes;
                            mem_wdata <= readData2;
                            cnt_q     <= 8'd0;
                            err_q     <= 1'b0;
                            state_q   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 8'd1;
                    // An ack arriving on the final allowed cycle still completes the access.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdata_q <= mem_we ? 16'd0 : mem_rdata;
                        err_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (cnt_q + 8'd1 == TO_LIM) begin
                        mem_req <= 1'b0;
                        rdata_q <= 16'd0;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // MEM/WB: a stalled edge inserts a bubble; only the side-effecting fields are cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readDataOut <= 16'd0;
            ALUResOut   <= 16'd0;
            nextPCOut   <= 16'd0;
            writeRegOut <= 3'd0;
            regWriteOut <= 1'b0;
            memToRegOut <= 1'b0;
            haltOut     <= 1'b0;
            errOut      <= 1'b0;
        end else if (stall) begin
            regWriteOut <= 1'b0;
            haltOut     <= 1'b0;
            errOut      <= 1'b0;
        end else begin
            readDataOut <= ((state_q == DONE) && memRead) ? rdata_q : 16'd0;
            ALUResOut   <= ALURes;
            nextPCOut   <= nextPC;
            writeRegOut <= writeReg;
            regWriteOut <= regWrite;
            memToRegOut <= memToReg;
            haltOut     <= halt;
            errOut      <= (state_q == DONE) ? err_q : 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, non-memory ops, loads/stores with varied ack latency, timeout, alignment.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ALURes = 16'd0, readData2 = 16'd0, nextPC = 16'd0, mem_rdata = 16'd0;
    logic [2:0]  writeReg = 3'd0;
    logic        regWrite = 1'b0, memToReg = 1'b0, memRead = 1'b0, memWrite = 1'b0;
    logic        halt = 1'b0, mem_ack = 1'b0;
    logic        stall, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, readDataOut, ALUResOut, nextPCOut;
    logic [2:0]  writeRegOut;
    logic        regWriteOut, memToRegOut, haltOut, errOut;

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;
    int base = 0;

    mem_stage #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst), .ALURes(ALURes), .readData2(readData2), .nextPC(nextPC),
        .writeReg(writeReg), .regWrite(regWrite), .memToReg(memToReg), .memRead(memRead),
        .memWrite(memWrite), .halt(halt), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .readDataOut(readDataOut), .ALUResOut(ALUResOut), .nextPCOut(nextPCOut),
        .writeRegOut(writeRegOut), .regWriteOut(regWriteOut), .memToRegOut(memToRegOut),
        .haltOut(haltOut), .errOut(errOut)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (stall === 1'b1) stall_cnt++;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic nop();
        memRead = 1'b0; memWrite = 1'b0; regWrite = 1'b0; memToReg = 1'b0; halt = 1'b0;
    endtask

    task automatic load(input logic [15:0] addr, input logic [2:0] rd);
        ALURes = addr; memRead = 1'b1; memWrite = 1'b0; memToReg = 1'b1;
        regWrite = 1'b1; writeReg = rd; halt = 1'b0;
    endtask

    initial begin
        // Reset from unknown state
        #1 rst = 1'b1;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_readData", readDataOut, 0);
        chk("rst_aluOut", ALUResOut, 0);
        chk("rst_regWrite", regWriteOut, 0);
        chk("rst_stall", stall, 0);
        tick();
        rst = 1'b0;
        tick();

        // Non-memory op
        base = stall_cnt;
        ALURes = 16'h1234; regWrite = 1'b1; writeReg = 3'd3; nextPC = 16'h0102;
        #1 chk("nop_stall", stall, 0);
        tick();
        chk("nop_alu", ALUResOut, 16'h1234);
        chk("nop_regw", regWriteOut, 1);
        chk("nop_wreg", writeRegOut, 3);
        chk("nop_pc", nextPCOut, 16'h0102);
        chk("nop_err", errOut, 0);

        // Halt passes through; ack while idle is ignored
        regWrite = 1'b0; halt = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        chk("halt_out", haltOut, 1);
        chk("idle_ack_req", mem_req, 0);
        chk("idle_ack_rd", readDataOut, 0);
        chk("nop_stall_cnt", stall_cnt - base, 0);
        mem_ack = 1'b0; halt = 1'b0;

        // Load, ack in first BUSY cycle
        base = stall_cnt;
        load(16'h0040, 3'd5);
        #1 chk("ld_stall_idle", stall, 1);
        tick();
        chk("ld_req", mem_req, 1);
        chk("ld_addr", mem_addr, 16'h0040);
        chk("ld_we", mem_we, 0);
        chk("ld_bubble", regWriteOut, 0);
        chk("ld_bubble_halt", haltOut, 0);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("ld_req_drop", mem_req, 0);
        chk("ld_done_stall", stall, 0);
        chk("ld_bubble2", regWriteOut, 0);
        tick();
        nop();
        chk("ld_data", readDataOut, 16'hBEEF);
        chk("ld_m2r", memToRegOut, 1);
        chk("ld_regw", regWriteOut, 1);
        chk("ld_wreg", writeRegOut, 5);
        chk("ld_err", errOut, 0);
        chk("ld_stall_cnt", stall_cnt - base, 2);

        // Store, ack delayed 4 cycles, ack held into DONE is ignored
        tick();
        base = stall_cnt;
        ALURes = 16'h0010; readData2 = 16'h00AA; memWrite = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("st_req", mem_req, 1);
            chk("st_we", mem_we, 1);
            chk("st_addr", mem_addr, 16'h0010);
            chk("st_wdata", mem_wdata, 16'h00AA);
            if (i == 4) begin mem_ack = 1'b1; mem_rdata = 16'h5555; end
            tick();
        end
        chk("st_req_drop", mem_req, 0);
        tick();
        mem_ack = 1'b0; nop();
        chk("st_rdata", readDataOut, 0);
        chk("st_err", errOut, 0);
        chk("st_stall_cnt", stall_cnt - base, 6);
        chk("st_req_idle", mem_req, 0);

        // Timeout: no ack for 15 BUSY cycles
        tick();
        base = stall_cnt;
        load(16'h0080, 3'd2);
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("to_req_last", mem_req, 1);
        tick();
        chk("to_req_drop", mem_req, 0);
        tick();
        nop();
        chk("to_err", errOut, 1);
        chk("to_rdata", readDataOut, 0);
        chk("to_regw", regWriteOut, 1);
        chk("to_stall_cnt", stall_cnt - base, 16);
        tick();
        chk("to_resume_err", errOut, 0);
        chk("to_resume_regw", regWriteOut, 0);

        // Ack on the timeout cycle wins
        load(16'h0090, 3'd1);
        tick();
        for (int i = 0; i < 14; i++) tick();
        mem_ack = 1'b1; mem_rdata = 16'h1357;
        tick();
        mem_ack = 1'b0;
        chk("lim_req_drop", mem_req, 0);
        tick();
        nop();
        chk("lim_err", errOut, 0);
        chk("lim_rdata", readDataOut, 16'h1357);
        tick();

        // Odd address
        base = stall_cnt;
        load(16'h0041, 3'd4);
        tick();
`ifdef ALIGN_CHECK_EN
        chk("al_req", mem_req, 0);
        chk("al_stall", stall, 0);
        tick();
        nop();
        chk("al_err", errOut, 1);
        chk("al_rdata", readDataOut, 0);
        chk("al_stall_cnt", stall_cnt - base, 1);
`else
        chk("al_req", mem_req, 1);
        chk("al_addr", mem_addr, 16'h0041);
        mem_ack = 1'b1; mem_rdata = 16'h2468;
        tick();
        mem_ack = 1'b0;
        tick();
        nop();
        chk("al_err", errOut, 0);
        chk("al_rdata", readDataOut, 16'h2468);
`endif
        tick();

        // Asynchronous reset in the middle of BUSY
        load(16'h0020, 3'd6);
        tick();
        chk("rb_req", mem_req, 1);
        #1 rst = 1'b1;
        #1;
        chk("rb_req_drop", mem_req, 0);
        chk("rb_addr", mem_addr, 0);
        chk("rb_alu", ALUResOut, 0);
        chk("rb_pc", nextPCOut, 0);
        chk("rb_rdata", readDataOut, 0);
        chk("rb_wreg", writeRegOut, 0);
        chk("rb_m2r", memToRegOut, 0);
        chk("rb_err", errOut, 0);
        nop();
        #1 chk("rb_stall", stall, 0);
        #2 rst = 1'b0;
        ALURes = 16'h0777; regWrite = 1'b1; writeReg = 3'd7;
        tick();
        chk("rb_after_alu", ALUResOut, 16'h0777);
        chk("rb_after_req", mem_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
